// File: rtl/yarp_pkg.sv
// Shared types and constants for the yarp core front end.
package yarp_pkg;

    localparam int unsigned YARP_FETCH_DEPTH = 4;
    localparam int unsigned XLEN             = 32;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Fetch addresses are always word aligned.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/yarp_fetch_fifo.sv
// Prefetch queue of {pc, instr} entries; flush empties it in one cycle.
module yarp_fetch_fifo
    import yarp_pkg::*;
#(
    parameter int unsigned DEPTH = YARP_FETCH_DEPTH,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output fetch_entry_t     head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) r_mem[r_wr_ptr] <= push_data;
    end

    assign count = r_count;
    assign empty = (r_count == '0);
    assign head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/yarp_fetch.sv
// Decoupled instruction fetch: pipelined memory requests feeding a prefetch
// queue, with redirect flush and discard of stale in-flight responses.
module yarp_fetch
    import yarp_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h1000,
    parameter int unsigned DEPTH    = YARP_FETCH_DEPTH
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        instr_mem_req_o,
    output logic [31:0] instr_mem_addr_o,
    input  logic        instr_mem_gnt_i,
    input  logic        instr_mem_rvalid_i,
    input  logic [31:0] instr_mem_rd_data_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [31:0]      r_fetch_pc;
    logic [31:0]      r_resp_pc;
    logic [CNT_W-1:0] r_outstanding;
    logic [CNT_W-1:0] r_discard;

    logic [CNT_W-1:0] w_count;
    logic             w_empty;
    fetch_entry_t     w_head;
    fetch_entry_t     w_push_data;
    logic             w_credit;
    logic             w_fire;
    logic             w_resp;
    logic             w_push;
    logic             w_pop;
    logic [31:0]      w_redirect_pc;

    // Credit covers queue slots already taken plus responses still owed.
    assign w_credit      = (SUM_W'(w_count) + SUM_W'(r_outstanding)) < SUM_W'(DEPTH);
    assign w_fire        = instr_mem_req_o & instr_mem_gnt_i;
    assign w_resp        = instr_mem_rvalid_i & (r_outstanding != '0);
    assign w_push        = w_resp & ~redirect_i & (r_discard == '0);
    assign w_pop         = ~w_empty & instr_ready_i;
    assign w_redirect_pc = word_align(redirect_pc_i);
    assign w_push_data   = '{pc: r_resp_pc, instr: instr_mem_rd_data_i};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            if (redirect_i) begin
                r_fetch_pc <= w_redirect_pc;
                r_resp_pc  <= w_redirect_pc;
                r_discard  <= r_outstanding - CNT_W'(w_resp);
            end else begin
                if (w_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_push) r_resp_pc  <= r_resp_pc + 32'd4;
                if (w_resp && (r_discard != '0)) r_discard <= r_discard - CNT_W'(1);
            end
            case ({w_fire, w_resp})
                2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    yarp_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .flush     (redirect_i),
        .count     (w_count),
        .empty     (w_empty),
        .head      (w_head)
    );

    assign instr_mem_req_o  = reset_n & ~redirect_i & w_credit;
    assign instr_mem_addr_o = r_fetch_pc;
    assign instr_valid_o    = ~w_empty;
    assign instr_o          = w_head.instr;
    assign instr_pc_o       = w_head.pc;

endmodule

// File: tb/tb_yarp_fetch.sv
// Directed bench for yarp_fetch with a fixed-latency in-order memory model.
module tb_yarp_fetch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        instr_mem_req_o;
    logic [31:0] instr_mem_addr_o;
    logic        instr_mem_gnt_i;
    logic        instr_mem_rvalid_i;
    logic [31:0] instr_mem_rd_data_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;

    always #5 clk = ~clk;

    yarp_fetch #(.RESET_PC(32'h1000), .DEPTH(4)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .instr_mem_req_o     (instr_mem_req_o),
        .instr_mem_addr_o    (instr_mem_addr_o),
        .instr_mem_gnt_i     (instr_mem_gnt_i),
        .instr_mem_rvalid_i  (instr_mem_rvalid_i),
        .instr_mem_rd_data_i (instr_mem_rd_data_i),
        .redirect_i          (redirect_i),
        .redirect_pc_i       (redirect_pc_i),
        .instr_valid_o       (instr_valid_o),
        .instr_o             (instr_o),
        .instr_pc_o          (instr_pc_o),
        .instr_ready_i       (instr_ready_i)
    );

    int n_chk;
    int n_fail;
    int cyc;
    int lat;

    logic        s_req;
    logic        s_valid;
    logic [31:0] s_addr;
    logic [31:0] s_pc;
    logic [31:0] s_instr;

    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] gnt_addr[$];
    int          gnt_cyc[$];
    logic [31:0] dlv_pc[$];
    logic [31:0] dlv_instr[$];
    int          dlv_cyc[$];

    // One clock: sample at negedge, log handshakes, then drive next-cycle response.
    task automatic step();
        logic fire;
        @(negedge clk);
        s_req   = instr_mem_req_o;
        s_addr  = instr_mem_addr_o;
        s_valid = instr_valid_o;
        s_pc    = instr_pc_o;
        s_instr = instr_o;
        fire    = s_req & instr_mem_gnt_i;
        if (s_valid && instr_ready_i) begin
            dlv_pc.push_back(s_pc);
            dlv_instr.push_back(s_instr);
            dlv_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        if (instr_mem_rvalid_i && pend_addr.size() > 0) begin
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        if (fire) begin
            pend_addr.push_back(s_addr);
            pend_due.push_back(cyc + lat);
            gnt_addr.push_back(s_addr);
            gnt_cyc.push_back(cyc);
        end
        cyc++;
        if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            instr_mem_rvalid_i  = 1'b1;
            instr_mem_rd_data_i = ~pend_addr[0];
        end else begin
            instr_mem_rvalid_i  = 1'b0;
            instr_mem_rd_data_i = 32'h0;
        end
    endtask

    task automatic clear_logs();
        gnt_addr.delete();
        gnt_cyc.delete();
        dlv_pc.delete();
        dlv_instr.delete();
        dlv_cyc.delete();
    endtask

    task automatic do_reset();
        reset_n            = 1'b0;
        redirect_i         = 1'b0;
        instr_mem_rvalid_i = 1'b0;
        @(posedge clk);
        #1;
        pend_addr.delete();
        pend_due.delete();
        instr_mem_rvalid_i = 1'b0;
        reset_n            = 1'b1;
        clear_logs();
    endtask

    task automatic test_reset();
        instr_mem_gnt_i = 1'b1;
        instr_ready_i   = 1'b1;
        reset_n         = 1'b0;
        @(posedge clk);
        #1;
        n_chk++; if (instr_mem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0b want 0", instr_mem_req_o); end
        n_chk++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", instr_valid_o); end
        n_chk++; if (instr_mem_addr_o !== 32'h1000) begin n_fail++; $display("FAIL reset_addr: got %h want 00001000", instr_mem_addr_o); end
        pend_addr.delete();
        pend_due.delete();
        reset_n = 1'b1;
        clear_logs();
        #1;
        n_chk++; if (instr_mem_req_o !== 1'b1) begin n_fail++; $display("FAIL reset_release_req: got %0b want 1", instr_mem_req_o); end
        // Stray response with nothing outstanding must be ignored.
        instr_mem_gnt_i     = 1'b0;
        instr_mem_rvalid_i  = 1'b1;
        instr_mem_rd_data_i = 32'hDEAD_BEEF;
        step();
        step();
        n_chk++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL proto_err_valid: got %0b want 0", s_valid); end
        instr_mem_gnt_i = 1'b1;
        lat = 1;
        repeat (4) step();
        n_chk++;
        if (dlv_pc.size() < 1) begin n_fail++; $display("FAIL proto_err_resume: got %0d entries want >=1", dlv_pc.size()); end
        else if (dlv_pc[0] !== 32'h1000) begin n_fail++; $display("FAIL proto_err_resume: got %h want 00001000", dlv_pc[0]); end
    endtask

    task automatic test_stream();
        do_reset();
        instr_mem_gnt_i = 1'b1;
        instr_ready_i   = 1'b1;
        lat             = 1;
        repeat (12) step();
        n_chk++;
        if (gnt_addr.size() < 8) begin n_fail++; $display("FAIL stream_gnt_count: got %0d want >=8", gnt_addr.size()); end
        else begin
            for (int i = 0; i < 8; i++) begin
                n_chk++; if (gnt_addr[i] !== 32'h1000 + 32'(4 * i)) begin n_fail++; $display("FAIL stream_addr[%0d]: got %h want %h", i, gnt_addr[i], 32'h1000 + 32'(4 * i)); end
                n_chk++; if (gnt_cyc[i] != gnt_cyc[0] + i) begin n_fail++; $display("FAIL stream_gnt_cyc[%0d]: got %0d want %0d", i, gnt_cyc[i], gnt_cyc[0] + i); end
            end
        end
        n_chk++;
        if (dlv_pc.size() < 6) begin n_fail++; $display("FAIL stream_dlv_count: got %0d want >=6", dlv_pc.size()); end
        else begin
            n_chk++; if (dlv_cyc[0] != gnt_cyc[0] + 2) begin n_fail++; $display("FAIL stream_latency: got %0d want %0d", dlv_cyc[0], gnt_cyc[0] + 2); end
            for (int i = 0; i < 6; i++) begin
                n_chk++; if (dlv_pc[i] !== 32'h1000 + 32'(4 * i)) begin n_fail++; $display("FAIL stream_pc[%0d]: got %h want %h", i, dlv_pc[i], 32'h1000 + 32'(4 * i)); end
                n_chk++; if (dlv_instr[i] !== ~(32'h1000 + 32'(4 * i))) begin n_fail++; $display("FAIL stream_instr[%0d]: got %h want %h", i, dlv_instr[i], ~(32'h1000 + 32'(4 * i))); end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        instr_mem_gnt_i = 1'b1;
        instr_ready_i   = 1'b0;
        lat             = 1;
        repeat (10) step();
        n_chk++; if (gnt_addr.size() != 4) begin n_fail++; $display("FAIL bp_grants: got %0d want 4", gnt_addr.size()); end
        n_chk++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL bp_req_full: got %0b want 0", s_req); end
        n_chk++; if (s_valid !== 1'b1 || s_pc !== 32'h1000) begin n_fail++; $display("FAIL bp_head: got valid %0b pc %h want 1 00001000", s_valid, s_pc); end
        instr_ready_i = 1'b1;
        step();
        n_chk++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL bp_req_pop_cycle: got %0b want 0", s_req); end
        step();
        n_chk++; if (s_req !== 1'b1) begin n_fail++; $display("FAIL bp_req_after_pop: got %0b want 1", s_req); end
        repeat (8) step();
        n_chk++;
        if (dlv_pc.size() < 6) begin n_fail++; $display("FAIL bp_dlv_count: got %0d want >=6", dlv_pc.size()); end
        else begin
            for (int i = 0; i < 6; i++) begin
                n_chk++; if (dlv_pc[i] !== 32'h1000 + 32'(4 * i)) begin n_fail++; $display("FAIL bp_pc[%0d]: got %h want %h", i, dlv_pc[i], 32'h1000 + 32'(4 * i)); end
            end
            for (int i = 1; i < 4; i++) begin
                n_chk++; if (dlv_cyc[i] != dlv_cyc[0] + i) begin n_fail++; $display("FAIL bp_pop_cyc[%0d]: got %0d want %0d", i, dlv_cyc[i], dlv_cyc[0] + i); end
            end
        end
    endtask

    task automatic test_redirect_latency();
        int bad;
        do_reset();
        instr_mem_gnt_i = 1'b1;
        instr_ready_i   = 1'b1;
        lat             = 3;
        repeat (3) step();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h2002;
        step();
        n_chk++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL rdl_req_on_redirect: got %0b want 0", s_req); end
        redirect_i = 1'b0;
        step();
        n_chk++;
        if (gnt_addr.size() != 4) begin n_fail++; $display("FAIL rdl_gnt_count: got %0d want 4", gnt_addr.size()); end
        else if (gnt_addr[3] !== 32'h2000) begin n_fail++; $display("FAIL rdl_next_addr: got %h want 00002000", gnt_addr[3]); end
        repeat (12) step();
        n_chk++;
        if (dlv_pc.size() < 3) begin n_fail++; $display("FAIL rdl_dlv_count: got %0d want >=3", dlv_pc.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                n_chk++; if (dlv_pc[i] !== 32'h2000 + 32'(4 * i)) begin n_fail++; $display("FAIL rdl_pc[%0d]: got %h want %h", i, dlv_pc[i], 32'h2000 + 32'(4 * i)); end
                n_chk++; if (dlv_instr[i] !== ~(32'h2000 + 32'(4 * i))) begin n_fail++; $display("FAIL rdl_instr[%0d]: got %h want %h", i, dlv_instr[i], ~(32'h2000 + 32'(4 * i))); end
            end
        end
        bad = 0;
        foreach (dlv_pc[i]) if (dlv_pc[i] < 32'h2000) bad++;
        n_chk++; if (bad != 0) begin n_fail++; $display("FAIL rdl_stale_delivered: got %0d stale entries want 0", bad); end
    endtask

    task automatic test_redirect_pop();
        int n;
        do_reset();
        instr_mem_gnt_i = 1'b1;
        instr_ready_i   = 1'b1;
        lat             = 1;
        repeat (6) step();
        n_chk++; if (instr_mem_rvalid_i !== 1'b1 || instr_valid_o !== 1'b1) begin n_fail++; $display("FAIL rdp_setup: got rvalid %0b valid %0b want 1 1", instr_mem_rvalid_i, instr_valid_o); end
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h5000;
        step();
        redirect_i = 1'b0;
        n = dlv_pc.size();
        step();
        n_chk++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL rdp_flush_valid: got %0b want 0", s_valid); end
        n_chk++; if (s_addr !== 32'h5000 || s_req !== 1'b1) begin n_fail++; $display("FAIL rdp_refetch: got req %0b addr %h want 1 00005000", s_req, s_addr); end
        step();
        n_chk++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL rdp_still_empty: got %0b want 0", s_valid); end
        repeat (4) step();
        n_chk++;
        if (dlv_pc.size() < n + 2) begin n_fail++; $display("FAIL rdp_dlv_count: got %0d want >=%0d", dlv_pc.size(), n + 2); end
        else begin
            n_chk++; if (dlv_pc[n] !== 32'h5000) begin n_fail++; $display("FAIL rdp_first_pc: got %h want 00005000", dlv_pc[n]); end
            n_chk++; if (dlv_pc[n + 1] !== 32'h5004) begin n_fail++; $display("FAIL rdp_second_pc: got %h want 00005004", dlv_pc[n + 1]); end
        end
    endtask

    task automatic test_back_to_back_redirect();
        int n;
        int ng;
        do_reset();
        instr_mem_gnt_i = 1'b1;
        instr_ready_i   = 1'b1;
        lat             = 3;
        repeat (5) step();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h3000;
        step();
        redirect_pc_i = 32'h4000;
        step();
        redirect_i = 1'b0;
        n  = dlv_pc.size();
        ng = gnt_addr.size();
        repeat (15) step();
        n_chk++;
        if (gnt_addr.size() <= ng) begin n_fail++; $display("FAIL b2b_gnt_count: got %0d want >%0d", gnt_addr.size(), ng); end
        else if (gnt_addr[ng] !== 32'h4000) begin n_fail++; $display("FAIL b2b_next_addr: got %h want 00004000", gnt_addr[ng]); end
        n_chk++;
        if (dlv_pc.size() < n + 3) begin n_fail++; $display("FAIL b2b_dlv_count: got %0d want >=%0d", dlv_pc.size(), n + 3); end
        else begin
            for (int i = n; i < dlv_pc.size(); i++) begin
                n_chk++; if (dlv_pc[i] !== 32'h4000 + 32'(4 * (i - n))) begin n_fail++; $display("FAIL b2b_pc[%0d]: got %h want %h", i - n, dlv_pc[i], 32'h4000 + 32'(4 * (i - n))); end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        instr_mem_gnt_i = 1'b1;
        instr_ready_i   = 1'b0;
        lat             = 3;
        repeat (5) step();
        n_chk++; if (instr_valid_o !== 1'b1 || instr_mem_req_o !== 1'b0) begin n_fail++; $display("FAIL rstm_setup: got valid %0b req %0b want 1 0", instr_valid_o, instr_mem_req_o); end
        reset_n = 1'b0;
        step();
        n_chk++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL rstm_req_in_reset: got %0b want 0", s_req); end
        n_chk++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL rstm_valid: got %0b want 0", instr_valid_o); end
        n_chk++; if (instr_mem_req_o !== 1'b0) begin n_fail++; $display("FAIL rstm_req_after_edge: got %0b want 0", instr_mem_req_o); end
        n_chk++; if (instr_mem_addr_o !== 32'h1000) begin n_fail++; $display("FAIL rstm_addr: got %h want 00001000", instr_mem_addr_o); end
        pend_addr.delete();
        pend_due.delete();
        instr_mem_rvalid_i = 1'b0;
        reset_n            = 1'b1;
        instr_ready_i      = 1'b1;
        lat                = 1;
        clear_logs();
        repeat (6) step();
        n_chk++;
        if (gnt_addr.size() < 1) begin n_fail++; $display("FAIL rstm_restart_gnt: got 0 grants want >=1"); end
        else if (gnt_addr[0] !== 32'h1000) begin n_fail++; $display("FAIL rstm_restart_addr: got %h want 00001000", gnt_addr[0]); end
        n_chk++;
        if (dlv_pc.size() < 2) begin n_fail++; $display("FAIL rstm_dlv_count: got %0d want >=2", dlv_pc.size()); end
        else begin
            n_chk++; if (dlv_pc[0] !== 32'h1000) begin n_fail++; $display("FAIL rstm_first_pc: got %h want 00001000", dlv_pc[0]); end
            n_chk++; if (dlv_pc[1] !== 32'h1004) begin n_fail++; $display("FAIL rstm_second_pc: got %h want 00001004", dlv_pc[1]); end
        end
    endtask

    initial begin
        n_chk               = 0;
        n_fail              = 0;
        cyc                 = 0;
        lat                 = 1;
        reset_n             = 1'b0;
        instr_mem_gnt_i     = 1'b0;
        instr_mem_rvalid_i  = 1'b0;
        instr_mem_rd_data_i = 32'h0;
        redirect_i          = 1'b0;
        redirect_pc_i       = 32'h0;
        instr_ready_i       = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_latency();
        test_redirect_pop();
        test_back_to_back_redirect();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
